// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Define ALU_MULDIV_FAST_MUL_EN to compute all multiply ops in a single cycle.
module alu_muldiv #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic [OP_WIDTH-1:0]   MulDivOp,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] MulDivResult
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_next;
  logic           in_ready_d;
  logic           accept;
  logic           last;

  logic [2:0]     op3;
  logic [2:0]     op_q;
  logic           neg_q;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   hi, lo, opnd;

  logic           a_signed, b_signed, sa, sb;
  logic [W-1:0]   a_mag, b_mag;
  logic           neg_d, b_zero, ovf, special;
  logic [W-1:0]   spec_res;
  logic           fast_hit;
  logic [W-1:0]   fast_res;

  logic [W:0]     sum, sh, diff;
  logic [W-1:0]   hi_s, lo_s;
  logic [2*W-1:0] prod, prod_f;
  logic [W-1:0]   qr, qr_f, final_res;

  assign op3    = MulDivOp[2:0];
  assign accept = in_valid && in_ready && !flush;
  assign last   = (cnt == CW'(W - 1));

  // State register; in_ready is registered alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= in_ready_d;
    end
  end

  // Next-state logic; flush always wins over normal progress
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (special || fast_hit) ? DONE : CALC;
      CALC: if (last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Output decode; the strobe is suppressed if the op is aborted in DONE
  always_comb begin
    in_ready_d = (state_next == IDLE);
    out_valid  = (state == DONE) && !flush;
  end

  // Operand signedness, magnitudes and special-case detection at accept
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (op3[2]) begin
      a_signed = ~op3[0];
      b_signed = ~op3[0];
    end else begin
      a_signed = (op3[1:0] != 2'b11);
      b_signed = ~op3[1];
    end
    sa      = a_signed & SrcA[W-1];
    sb      = b_signed & SrcB[W-1];
    a_mag   = sa ? -SrcA : SrcA;
    b_mag   = sb ? -SrcB : SrcB;
    neg_d   = (op3[2] && op3[1]) ? sa : (sa ^ sb);
    b_zero  = (SrcB == '0);
    ovf     = !op3[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
    special = op3[2] && (b_zero || ovf);
    if (b_zero) spec_res = op3[1] ? SrcA : '1;
    else        spec_res = op3[1] ? '0 : SrcA;
  end

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fa, fb, fp;

  // Sign-extended 2W x 2W product truncated to 2W bits is the exact signed product
  always_comb begin
    fa       = {{W{sa}}, SrcA};
    fb       = {{W{sb}}, SrcB};
    fp       = fa * fb;
    fast_hit = ~op3[2];
    fast_res = (op3[1:0] == 2'b00) ? fp[W-1:0] : fp[2*W-1:W];
  end
`else
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
  end
`endif

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    sh   = {hi, lo[W-1]};
    diff = sh - {1'b0, opnd};
    if (op_q[2]) begin
      if (!diff[W]) begin
        hi_s = diff[W-1:0];
        lo_s = {lo[W-2:0], 1'b1};
      end else begin
        hi_s = sh[W-1:0];
        lo_s = {lo[W-2:0], 1'b0};
      end
    end else begin
      hi_s = sum[W:1];
      lo_s = {sum[0], lo[W-1:1]};
    end
  end

  // Sign fix-up and result selection from the final iteration's values
  always_comb begin
    prod      = {hi_s, lo_s};
    prod_f    = neg_q ? -prod : prod;
    qr        = op_q[1] ? hi_s : lo_s;
    qr_f      = neg_q ? -qr : qr;
    final_res = op_q[2] ? qr_f
              : ((op_q[1:0] == 2'b00) ? prod_f[W-1:0] : prod_f[2*W-1:W]);
  end

  // Datapath registers: mul keeps {acc, multiplier}, div keeps {remainder, quotient}
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= '0;
      neg_q        <= 1'b0;
      cnt          <= '0;
      hi           <= '0;
      lo           <= '0;
      opnd         <= '0;
      MulDivResult <= '0;
    end else if (accept) begin
      op_q  <= op3;
      neg_q <= neg_d;
      cnt   <= '0;
      hi    <= '0;
      lo    <= op3[2] ? a_mag : b_mag;
      opnd  <= op3[2] ? b_mag : a_mag;
      if (special)       MulDivResult <= spec_res;
      else if (fast_hit) MulDivResult <= fast_res;
    end else if (state == CALC && !flush) begin
      hi  <= hi_s;
      lo  <= lo_s;
      cnt <= cnt + CW'(1);
      if (last) MulDivResult <= final_res;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (W=32): results, latency, flush and reset.
module tb_alu_muldiv;

  localparam int unsigned W = 32;
`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = W + 1;
`endif
  localparam int LAT_DIV = W + 1;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                         OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                         OP_REM = 3'b110, OP_REMU = 3'b111;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcA, SrcB;
  logic [2:0]   MulDivOp;
  logic         flush;
  logic         out_valid;
  logic [W-1:0] MulDivResult;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .MulDivOp(MulDivOp), .flush(flush),
    .out_valid(out_valid), .MulDivResult(MulDivResult)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one op, measure cycles to out_valid, check result and handshake
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int  k;
    int  ready_hi;
    bit  seen;
    @(negedge clk);
    in_valid = 1'b1; MulDivOp = op; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; MulDivOp = 3'($urandom);
    k = 0; ready_hi = 0; seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (in_ready) ready_hi++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(k), 32'(lat));
    check({tag, "_res"}, MulDivResult, exp);
    check({tag, "_busy"}, 32'(ready_hi), 32'd0);
    @(negedge clk);
    check({tag, "_ov_off"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    SrcA = '0; SrcB = '0; MulDivOp = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_res", MulDivResult, 32'd0);

    run_op("mul_neg",   OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL);
    run_op("mulh_min",  OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL);
    run_op("mulhu_max", OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL);
    run_op("mulhsu",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL);
    run_op("mulh_m1x5", OP_MULH,   32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, LAT_MUL);
    run_op("div_neg",   OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_DIV);
    run_op("rem_neg",   OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_DIV);
    run_op("div_nn",    OP_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        LAT_DIV);
    run_op("rem_pn",    OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        LAT_DIV);
    run_op("divu",      OP_DIVU,   32'd100,      32'd7,        32'd14,       LAT_DIV);
    run_op("remu",      OP_REMU,   32'd100,      32'd7,        32'd2,        LAT_DIV);
    run_op("divu_big",  OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_DIV);
    run_op("div_z",     OP_DIV,    32'h1234,     32'd0,        32'hFFFFFFFF, 1);
    run_op("divu_z",    OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_z",    OP_REMU,   32'h1234,     32'd0,        32'h1234,     1);
    run_op("rem_z",     OP_REM,    32'h1234,     32'd0,        32'h1234,     1);
    run_op("div_ovf",   OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",   OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Flush in the 10th CALC cycle of a DIVU
    @(negedge clk);
    in_valid = 1'b1; MulDivOp = OP_DIVU; SrcA = 32'd1000; SrcB = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; SrcA = 32'd9; SrcB = 32'd3;
    @(negedge clk);
    check("flc_ov", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flc_rdy", 32'(in_ready), 32'd1);
    check("flc_ov2", 32'(out_valid), 32'd0);
    watch_quiet("flc_quiet", 40);
    run_op("divu_post", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_DIV);

    // Flush arriving in DONE suppresses the strobe
    @(negedge clk);
    in_valid = 1'b1; MulDivOp = OP_DIV; SrcA = 32'h1234; SrcB = 32'd0;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("fld_ov", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("fld_rdy", 32'(in_ready), 32'd1);
    check("fld_ov2", 32'(out_valid), 32'd0);

    // Reset mid-CALC, with flush asserted alongside
    @(negedge clk);
    in_valid = 1'b1; MulDivOp = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("mrst_rdy", 32'(in_ready), 32'd1);
    check("mrst_ov", 32'(out_valid), 32'd0);
    check("mrst_res", MulDivResult, 32'd0);
    watch_quiet("mrst_quiet", 40);
    run_op("mul_6x7", OP_MUL, 32'd6, 32'd7, 32'd42, LAT_MUL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
